ram16_drain: RTL
================

// Module: ram16_drain
// PURPOSE
//   Read-side controller for the RAM16 word buffer: waits for FULL, reads every word
//   from address 0 to DEPTH-1, streams each word out on a valid/ready port, then pulses
//   the RAM's CLR. The writer fills the buffer; this block empties and re-arms it.
// PARAMETERS
//   ADDR_WIDTH  2   RAM address width; DEPTH = 2**ADDR_WIDTH words
//   DATA_WIDTH  16  word width; must match the RAM data width
// PORTS
//   CLK        in   1           system clock, all logic on rising edge
//   RST        in   1           synchronous, active-high reset
//   FULL       in   1           RAM full flag
//   RAM_EN     out  1           RAM enable
//   RAM_WE     out  1           RAM write enable; tied 0
//   RAM_CLR    out  1           RAM clear, one-cycle pulse
//   RAM_A      out  ADDR_WIDTH  RAM read address
//   RAM_DO     in   DATA_WIDTH  RAM read data, valid 1 cycle after RAM_EN/RAM_A
//   OUT_DATA   out  DATA_WIDTH  streamed word
//   OUT_VALID  out  1           OUT_DATA valid
//   OUT_READY  in   1           sink accepts the word when OUT_VALID & OUT_READY
//   BUSY       out  1           high in every state except IDLE; writer must not write
//   DONE       out  1           one-cycle pulse after the CLR cycle
// BEHAVIOUR
//   Reset: all outputs 0, address counter 0, state IDLE. RAM contents are untouched.
//     A reset mid-drain aborts the drain with no CLR issued; FULL restarts the drain at address 0.
//   FSM (one-hot or encoded): IDLE, RD, CAP, PRES, [CKS], CLR, WAITF
//   IDLE:  FULL=1 -> RD. Otherwise hold.
//   RD:    RAM_EN=1, RAM_A=addr for exactly 1 cycle -> CAP.
//   CAP:   OUT_DATA<=RAM_DO; OUT_VALID<=1 -> PRES.
//   PRES:  hold OUT_DATA/OUT_VALID stable until OUT_READY.
//          On handshake, OUT_VALID<=0, then:
//            addr==DEPTH-1 -> CKS (if enabled) or CLR;
//            otherwise addr<=addr+1 -> RD.
//   CLR:   RAM_CLR=1 and RAM_EN=1 for exactly 1 cycle; addr<=0 -> WAITF.
//   WAITF: DONE=1 on the first cycle only; stay until FULL=0 -> IDLE. This prevents
//          retriggering on a stale FULL.
//   Throughput: minimum 3 cycles per word with OUT_READY held high.
//     Words are emitted in address order 0..DEPTH-1.
//   The address counter wraps naturally at DEPTH-1 but is explicitly cleared in CLR.
//   FULL dropping mid-drain is ignored; the drain always completes all DEPTH words.
//   OUT_READY high outside PRES has no effect. RAM_WE is never asserted.
// CONFIGURATION
//   DRAIN_CKSUM_EN defined:
//     - 16-bit running XOR of all drained words; cleared on reset and on entering RD at addr 0.
//     - After the last data handshake, state CKS presents the XOR as one extra word with
//       the same valid/ready rules, then -> CLR. DEPTH+1 words per frame.
//   DRAIN_CKSUM_EN undefined:
//     - No CKS state and no checksum register. Exactly DEPTH words per frame.
// TESTING (ADDR_WIDTH=2; RAM model with 1-cycle read latency, preloaded 0001..0004)
//   1 Reset then FULL=1, OUT_READY=1 -> OUT_DATA 0001,0002,0003,0004 in order,
//     one handshake each; RAM_CLR pulses one cycle; DONE pulses once; BUSY falls after FULL=0.
//   2 Backpressure: OUT_READY=0 for 5 cycles on word 0002 -> OUT_VALID stays 1,
//     OUT_DATA stays 0002, RAM_A stays 1, no extra RAM_EN.
//   3 FULL held high 10 cycles after CLR -> stays in WAITF, no second drain;
//     FULL=0 -> IDLE; FULL=1 again -> new drain from addr 0.
//   4 RST=1 while in PRES on word 0003 -> next cycle all outputs 0, no RAM_CLR;
//     FULL still 1 -> drain restarts at 0001.
//   5 DRAIN_CKSUM_EN: data 0001..0004 -> fifth word 0004 (1^2^3^4), then CLR;
//     a second frame 00FF,0F00,F000,0001 -> checksum FFFE.
//   6 FULL deasserted during RD of addr 1 -> drain still emits all 4 words and issues CLR.

Source files
------------

// File: rtl/ram16_drain.sv
// ram16_drain: read-side controller for the RAM16 word buffer.
// Waits for full, reads every word from address 0 to the last address, streams each word
// out on a valid/ready port, then pulses the RAM clear and waits for full to drop.
//
// Optional feature (compile-time macro DRAIN_CKSUM_EN): appends a running-XOR checksum word
// after the data words of every frame.
//
// Parameters:
//   AddrWidth  RAM address width; the buffer holds 2**AddrWidth words
//   DataWidth  word width; must match the RAM data width (checksum is DataWidth bits)
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   full       RAM full flag
//   ram_en     RAM enable
//   ram_we     RAM write enable, always 0
//   ram_clr    RAM clear, one-cycle pulse
//   ram_a      RAM read address
//   ram_do     RAM read data, valid one cycle after ram_en/ram_a
//   out_data   streamed word
//   out_valid  out_data valid
//   out_ready  sink ready; transfer on out_valid & out_ready
//   busy       high whenever not idle; the writer must not write
//   done       one-cycle pulse after the clear cycle
module ram16_drain #(
  parameter int unsigned AddrWidth = 2,
  parameter int unsigned DataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 full,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic                 ram_clr,
  output logic [AddrWidth-1:0] ram_a,
  input  logic [DataWidth-1:0] ram_do,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StPres,
`ifdef DRAIN_CKSUM_EN
    StCks,
`endif
    StClr,
    StWaitf
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q;
  logic [DataWidth-1:0]   data_q;
  logic                   done_q;
  logic                   last_addr;

`ifdef DRAIN_CKSUM_EN
  logic [DataWidth-1:0]   cksum_q;
`endif

  // All-ones address is the last word of the buffer.
  assign last_addr = &addr_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (full) state_d = StRd;
      StRd:    state_d = StCap;
      StCap:   state_d = StPres;
      StPres: begin
        if (out_ready) begin
          if (last_addr) begin
`ifdef DRAIN_CKSUM_EN
            state_d = StCks;
`else
            state_d = StClr;
`endif
          end else begin
            state_d = StRd;
          end
        end
      end
`ifdef DRAIN_CKSUM_EN
      StCks:   if (out_ready) state_d = StClr;
`endif
      StClr:   state_d = StWaitf;
      // Hold here until full drops so a stale full cannot start a second drain.
      StWaitf: if (!full) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: address counter, captured word, done pulse, optional checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
`ifdef DRAIN_CKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      // done is high on the first WAITF cycle only.
      done_q <= (state_q == StClr);

      if (state_q == StCap) begin
        data_q <= ram_do;
      end

      if (state_q == StClr) begin
        addr_q <= '0;
      end else if ((state_q == StPres) && out_ready && !last_addr) begin
        addr_q <= addr_q + AddrWidth'(1);
      end

`ifdef DRAIN_CKSUM_EN
      if ((state_d == StRd) && (state_q != StRd) && (addr_q == '0)) begin
        cksum_q <= '0;
      end else if (state_q == StCap) begin
        cksum_q <= cksum_q ^ ram_do;
      end
`endif
    end
  end

  // Outputs decoded from the state.
  always_comb begin
    ram_we    = 1'b0;
    ram_en    = (state_q == StRd) || (state_q == StClr);
    ram_clr   = (state_q == StClr);
    ram_a     = addr_q;
    busy      = (state_q != StIdle);
    done      = done_q;
    out_valid = (state_q == StPres);
    out_data  = data_q;
`ifdef DRAIN_CKSUM_EN
    if (state_q == StCks) begin
      out_valid = 1'b1;
      out_data  = cksum_q;
    end
`endif
  end

endmodule
